// File: rtl/botupdt_pkg.sv
// rtl/botupdt_pkg.sv - shared FSM state type and default parameters for the BotInfo update responder
package botupdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACK_TIMEOUT = 255;
  localparam int BOT_INFO_W      = 32;

endpackage

// File: rtl/botupdt_fifo.sv
// rtl/botupdt_fifo.sv - first-word-fall-through snapshot FIFO, reads 0 when empty
module botupdt_fifo
  import botupdt_pkg::*;
#(
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  parameter int  WIDTH = BOT_INFO_W,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A pop on empty is ignored; a push when full only fits if a pop frees the head slot
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset because reads are masked while empty
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/botupdt_responder.sv
// rtl/botupdt_responder.sv - Rojobot update handshake responder with snapshot FIFO; BOTUPDT_TIMEOUT_EN adds an ack timeout
module botupdt_responder
  import botupdt_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            botupdt_sync,
  input  logic [31:0]                     bot_info,
  output logic                            int_ack,
  input  logic                            rd_en,
  output logic [31:0]                     rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            irq,
  output logic                            ovf,
  output logic                            tmo_err,
  input  logic                            clr
);

  state_t                   r_state;
  logic                     r_int_ack;
  logic                     r_ovf;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_sync_s;
  logic                     w_capture;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_drop;
  logic                     w_tmo_fire;

  assign w_sync_s  = r_sync[SYNC_STAGES-1];
  assign w_capture = (r_state == ST_CAPTURE);
  assign w_drop    = w_capture && w_full && !rd_en;
  assign int_ack   = r_int_ack;
  assign ovf       = r_ovf;
  assign irq       = !w_empty;

  // Synchronizer chain for the asynchronous handshake flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], botupdt_sync};
    end
  end

`ifdef BOTUPDT_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // A normal release on the same cycle as expiry takes precedence over the timeout
  assign w_tmo_fire = (r_state == ST_ACK) && w_sync_s &&
                      (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
  assign tmo_err    = r_tmo_err;

  // Ack-wait counter runs only while holding ACK and clears on any exit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_ACK) && w_sync_s && !w_tmo_fire) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Sticky timeout flag; a new timeout beats a concurrent clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo_fire | (r_tmo_err & ~clr);
    end
  end
`else
  // Without the timeout, ACK waits for release forever; the term is constant false
  assign w_tmo_fire = (ACK_TIMEOUT < 0);
  assign tmo_err    = 1'b0;
`endif

  // Handshake FSM: capture once per sync high-phase, hold ack until release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_int_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_int_ack <= 1'b0;
          if (w_sync_s) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_state   <= ST_ACK;
          r_int_ack <= 1'b1;
        end
        ST_ACK: begin
          if (!w_sync_s || w_tmo_fire) begin
            r_state   <= ST_IDLE;
            r_int_ack <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_int_ack <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag; a new drop beats a concurrent clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_drop | (r_ovf & ~clr);
    end
  end

  botupdt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_capture),
    .i_pop   (rd_en),
    .i_data  (bot_info),
    .o_data  (rd_data),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_botupdt_responder.sv
// tb/tb_botupdt_responder.sv - directed self-checking bench for botupdt_responder
module tb_botupdt_responder;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             botupdt_sync = 1'b0;
  logic [31:0]      bot_info = '0;
  logic             int_ack;
  logic             rd_en = 1'b0;
  logic [31:0]      rd_data;
  logic [CNT_W-1:0] count;
  logic             irq;
  logic             ovf;
  logic             tmo_err;
  logic             clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  botupdt_responder #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .botupdt_sync (botupdt_sync),
    .bot_info     (bot_info),
    .int_ack      (int_ack),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .count        (count),
    .irq          (irq),
    .ovf          (ovf),
    .tmo_err      (tmo_err),
    .clr          (clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (int_ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_update(input logic [31:0] v, output bit ok);
    bit ok_hi;
    bit ok_lo;
    bot_info     = v;
    botupdt_sync = 1'b1;
    wait_ack(1'b1, 12, ok_hi);
    botupdt_sync = 1'b0;
    wait_ack(1'b0, 12, ok_lo);
    ok = ok_hi && ok_lo;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (int_ack !== 1'b0) begin n_fail++; $display("FAIL reset_int_ack: got %0b expected 0", int_ack); end
    n_checks++;
    if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %08h expected 00000000", rd_data); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    n_checks++;
    if (ovf !== 1'b0 || tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%0b tmo=%0b expected 0 0", ovf, tmo_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bot_info     = 32'h1234_5678;
    botupdt_sync = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (int_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_early: got %0b expected 0", int_ack); end
    tick();
    n_checks++;
    if (int_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_latency: got %0b expected 1", int_ack); end
    n_checks++;
    if (count !== CNT_W'(1) || irq !== 1'b1) begin n_fail++; $display("FAIL single_count_irq: got count=%0d irq=%0b expected 1 1", count, irq); end
    n_checks++;
    if (rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL single_rd_data: got %08h expected 12345678", rd_data); end
    repeat (4) tick();
    n_checks++;
    if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_one_push: got %0d expected 1", count); end
    botupdt_sync = 1'b0;
    tick();
    tick();
    n_checks++;
    if (int_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_hold: got %0b expected 1", int_ack); end
    tick();
    n_checks++;
    if (int_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_release: got %0b expected 0", int_ack); end
    pop_one();
    n_checks++;
    if (count !== '0 || irq !== 1'b0 || rd_data !== 32'h0) begin n_fail++; $display("FAIL single_pop: got count=%0d irq=%0b data=%08h expected 0 0 00000000", count, irq, rd_data); end
  endtask

  task automatic test_empty_pop();
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (count !== '0 || rd_data !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL empty_pop: got count=%0d data=%08h irq=%0b expected 0 00000000 0", count, rd_data, irq); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL empty_pop_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_fill();
    bit ok;
    bit all_ok = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      do_update(32'(v), ok);
      all_ok = all_ok && ok;
    end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL fill_handshake: got ok=%0b expected 1", all_ok); end
    n_checks++;
    if (count !== CNT_W'(4) || ovf !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL fill_state: got count=%0d ovf=%0b irq=%0b expected 4 1 1", count, ovf, irq); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (rd_data !== 32'(i)) begin n_fail++; $display("FAIL fill_pop_%0d: got %08h expected %08h", i, rd_data, 32'(i)); end
      pop_one();
    end
    n_checks++;
    if (count !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got count=%0d irq=%0b expected 0 0", count, irq); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL fill_clr_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_full_pop();
    bit ok;
    bit all_ok = 1'b1;
    for (int v = 10; v <= 13; v++) begin
      do_update(32'(v), ok);
      all_ok = all_ok && ok;
    end
    n_checks++;
    if (!all_ok || count !== CNT_W'(4)) begin n_fail++; $display("FAIL full_prefill: got ok=%0b count=%0d expected 1 4", all_ok, count); end
    bot_info     = 32'd14;
    botupdt_sync = 1'b1;
    tick();
    tick();
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (count !== CNT_W'(4) || ovf !== 1'b0) begin n_fail++; $display("FAIL full_push_pop: got count=%0d ovf=%0b expected 4 0", count, ovf); end
    n_checks++;
    if (rd_data !== 32'd11 || int_ack !== 1'b1) begin n_fail++; $display("FAIL full_head: got data=%0d ack=%0b expected 11 1", rd_data, int_ack); end
    botupdt_sync = 1'b0;
    wait_ack(1'b0, 12, ok);
    for (int i = 11; i <= 14; i++) begin
      n_checks++;
      if (rd_data !== 32'(i)) begin n_fail++; $display("FAIL full_wrap_pop_%0d: got %0d expected %0d", i, rd_data, i); end
      pop_one();
    end
    n_checks++;
    if (count !== '0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", count); end
  endtask

  task automatic test_ack_hold();
    bit ok;
    bot_info     = 32'hA5A5_0001;
    botupdt_sync = 1'b1;
    wait_ack(1'b1, 12, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_ack_rise: got ok=%0b expected 1", ok); end
`ifdef BOTUPDT_TIMEOUT_EN
    begin
      int n_high = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (int_ack === 1'b1) n_high++;
        else break;
      end
      n_checks++;
      if (n_high != 8) begin n_fail++; $display("FAIL tmo_high_cycles: got %0d expected 8", n_high); end
    end
    n_checks++;
    if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %0b expected 1", tmo_err); end
    wait_ack(1'b1, 12, ok);
    n_checks++;
    if (!ok || count !== CNT_W'(2)) begin n_fail++; $display("FAIL tmo_recapture: got ok=%0b count=%0d expected 1 2", ok, count); end
    botupdt_sync = 1'b0;
    wait_ack(1'b0, 12, ok);
    n_checks++;
    if (!ok || tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_release: got ok=%0b tmo=%0b expected 1 1", ok, tmo_err); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clr: got %0b expected 0", tmo_err); end
    pop_one();
    pop_one();
`else
    repeat (20) tick();
    n_checks++;
    if (int_ack !== 1'b1 || tmo_err !== 1'b0) begin n_fail++; $display("FAIL hold_forever: got ack=%0b tmo=%0b expected 1 0", int_ack, tmo_err); end
    n_checks++;
    if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL hold_one_push: got %0d expected 1", count); end
    botupdt_sync = 1'b0;
    wait_ack(1'b0, 12, ok);
    pop_one();
`endif
    n_checks++;
    if (count !== '0) begin n_fail++; $display("FAIL hold_drained: got %0d expected 0", count); end
  endtask

  task automatic test_reset_mid_ack();
    bit ok;
    bot_info     = 32'hCAFE_F00D;
    botupdt_sync = 1'b1;
    wait_ack(1'b1, 12, ok);
    n_checks++;
    if (!ok || count !== CNT_W'(1)) begin n_fail++; $display("FAIL rst_ack_pre: got ok=%0b count=%0d expected 1 1", ok, count); end
    rst = 1'b1;
    tick();
    n_checks++;
    if (int_ack !== 1'b0 || count !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL rst_ack_drop: got ack=%0b count=%0d irq=%0b expected 0 0 0", int_ack, count, irq); end
    tick();
    rst = 1'b0;
    wait_ack(1'b1, 12, ok);
    n_checks++;
    if (!ok || count !== CNT_W'(1) || rd_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_recapture: got ok=%0b count=%0d data=%08h expected 1 1 cafef00d", ok, count, rd_data); end
    repeat (5) tick();
    n_checks++;
    if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL rst_single_capture: got %0d expected 1", count); end
    botupdt_sync = 1'b0;
    wait_ack(1'b0, 12, ok);
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_pop();
    test_fill();
    test_full_pop();
    test_ack_hold();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
